stream_upsizer: RTL and testbench

Width up-converter that sits directly upstream of the 32-bit valid/ready pipeline register stage. It accepts narrow IN_W-bit beats on a valid/ready slave port and packs RATIO beats, little-endian, into one IN_W*RATIO-bit word. A packet-end flag (s_last) closes a partial word early; the lanes actually filled are reported on m_keep. The registered output feeds the pipeline register's input interface directly.

---
 rtl/stream_upsizer.sv | 102 ++++++++++
 tb/tb_stream_upsizer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_upsizer.sv
// Width up-converter: packs RATIO narrow IN_W-bit beats, little-endian, into one registered
// wide word. s_last closes a partial word early, and m_keep marks the lanes that were filled.
module stream_upsizer #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IN_W-1:0]       s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [IN_W*RATIO-1:0] m_data,
    output logic [RATIO-1:0]      m_keep,
    output logic                  m_last
);
    localparam int unsigned OutW = IN_W * RATIO;
    localparam int unsigned AccW = IN_W * (RATIO - 1);
    localparam int unsigned CntW = $clog2(RATIO);
    localparam logic [CntW-1:0] CntMax = CntW'(RATIO - 1);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [AccW-1:0]  acc_q, acc_d;
    logic             m_valid_q, m_valid_d;
    logic [OutW-1:0]  m_data_q, m_data_d;
    logic [RATIO-1:0] m_keep_q, m_keep_d;
    logic             m_last_q, m_last_d;
    logic             accept;
    logic             complete;

    // s_ready depends only on registered state and m_ready, never on the slave inputs.
    assign s_ready  = ~m_valid_q | m_ready;
    assign accept   = s_valid & s_ready;
    assign complete = accept & (s_last | (cnt_q == CntMax));

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;

        if (complete) begin
            // Lanes below cnt come from the accumulator, lane cnt from the beat, the rest zero.
            m_data_d = '0;
            for (int unsigned k = 0; k < RATIO - 1; k++) begin
                if (CntW'(k) < cnt_q) begin
                    m_data_d[k*IN_W +: IN_W] = acc_q[k*IN_W +: IN_W];
                end
            end
            for (int unsigned k = 0; k < RATIO; k++) begin
                if (CntW'(k) == cnt_q) begin
                    m_data_d[k*IN_W +: IN_W] = s_data;
                end
                m_keep_d[k] = (CntW'(k) <= cnt_q);
            end
            m_last_d  = s_last;
            m_valid_d = 1'b1;
            cnt_d     = '0;
            acc_d     = '0;
        end else begin
            if (m_ready) begin
                m_valid_d = 1'b0;
            end
            if (accept) begin
                for (int unsigned k = 0; k < RATIO - 1; k++) begin
                    if (CntW'(k) == cnt_q) begin
                        acc_d[k*IN_W +: IN_W] = s_data;
                    end
                end
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// Scoreboard bench for stream_upsizer: expected words are queued as stimulus is issued and a
// monitor pops and compares every output handshake.
module tb_stream_upsizer;
    localparam int unsigned IN_W  = 8;
    localparam int unsigned RATIO = 4;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    stream_upsizer #(
        .IN_W (IN_W),
        .RATIO(RATIO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_last (s_last),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_keep (m_keep),
        .m_last (m_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        exp_q.push_back(w);
    endtask

    // Present a beat (called at posedge+2) and hold it until it is accepted.
    task automatic beat(input logic [7:0] d, input logic l);
        logic go;
        go      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int i = 0; i < 100 && !go; i++) begin
            @(negedge clk);
            go = s_ready;
            @(posedge clk);
            #2;
        end
        if (!go) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: data %0h never accepted", d);
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitor: every negedge with valid && ready is one transfer at the next posedge.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h keep %0h last %0b, none expected",
                         m_data, m_keep, m_last);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                check("word", 64'({m_data, m_keep, m_last}), 64'(w));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        clk     = 1'b0;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        m_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset m_valid", 64'(m_valid), 64'd0);
        check("reset m_data", 64'(m_data), 64'd0);
        check("reset m_keep", 64'(m_keep), 64'd0);
        check("reset m_last", 64'(m_last), 64'd0);
        check("reset s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(1);

        // Full word
        expect_word(32'h44332211, 4'hF, 1'b0);
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        beat(8'h44, 1'b0);
        idle(2);

        // Short packet, then next beat lands in lane 0
        expect_word(32'h0000BBAA, 4'h3, 1'b1);
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
        expect_word(32'h00000001, 4'h1, 1'b1);
        beat(8'h01, 1'b1);
        idle(3);

        // Backpressure: word held for 5 cycles while 0x55 waits
        m_ready = 1'b0;
        expect_word(32'hDDCCBBAA, 4'hF, 1'b0);
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b0);
        beat(8'hCC, 1'b0);
        beat(8'hDD, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h55;
        s_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall s_ready", 64'(s_ready), 64'd0);
            check("stall m_valid", 64'(m_valid), 64'd1);
            check("stall m_data", 64'(m_data), 64'hDDCCBBAA);
            check("stall m_keep", 64'(m_keep), 64'hF);
            @(posedge clk);
            #2;
        end
        m_ready = 1'b1;
        expect_word(32'h00000055, 4'h1, 1'b1);
        beat(8'h55, 1'b1);
        idle(3);

        // Throughput: 12 back-to-back beats
        expect_word(32'h04030201, 4'hF, 1'b0);
        expect_word(32'h08070605, 4'hF, 1'b0);
        expect_word(32'h0C0B0A09, 4'hF, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            beat(8'(i), 1'b0);
            check("throughput s_ready", 64'(s_ready), 64'd1);
        end
        idle(3);

        // Back-to-back single-beat packets: second completes while first drains
        expect_word(32'h0000007E, 4'h1, 1'b1);
        expect_word(32'h0000007F, 4'h1, 1'b1);
        beat(8'h7E, 1'b1);
        beat(8'h7F, 1'b1);
        check("no bubble m_valid", 64'(m_valid), 64'd1);
        check("no bubble m_data", 64'(m_data), 64'h7F);
        idle(3);

        // Reset mid-packet
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        s_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midreset m_valid", 64'(m_valid), 64'd0);
        check("midreset m_data", 64'(m_data), 64'd0);
        check("midreset m_keep", 64'(m_keep), 64'd0);
        check("midreset m_last", 64'(m_last), 64'd0);
        check("midreset s_ready", 64'(s_ready), 64'd1);
        #2 rst_n = 1'b1;
        idle(1);
        expect_word(32'hA4A3A2A1, 4'hF, 1'b0);
        beat(8'hA1, 1'b0);
        beat(8'hA2, 1'b0);
        beat(8'hA3, 1'b0);
        beat(8'hA4, 1'b0);
        s_valid = 1'b0;

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        idle(3);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
